// File: rtl/div8_seq.sv
// Sequential unsigned restoring divider built around addsub8; one trial subtraction per clock.
// Latency: WIDTH+1 edges from accepting start to done; divide-by-zero completes on the accepting edge.
// Backpressure: start is ignored while busy; a start held in the done cycle is accepted back-to-back.

module addsub8 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // For subtraction cout is the no-borrow flag, i.e. a >= b unsigned.
    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];
endmodule

module div8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r9;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic             qb;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    assign r9 = {r_reg, q_reg[WIDTH-1]};

    addsub8 #(.WIDTH(WIDTH)) u_addsub (
        .a    (r9[WIDTH-1:0]),
        .b    (d_reg),
        .sub  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    // The carry bit of r9 makes the 9-bit value exceed any divisor, so it forces a subtract.
    assign qb     = r9[WIDTH] | no_borrow;
    assign r_next = qb ? diff : r9[WIDTH-1:0];
    assign q_next = {q_reg[WIDTH-2:0], qb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            dz        <= 1'b1;
                        end else begin
                            d_reg <= divisor;
                            q_reg <= dividend;
                            r_reg <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                        dz        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div8_seq.sv
// Directed and random checks of div8_seq: latency, handshake, divide-by-zero, ignored restarts, abort by reset.
module tb_div8_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'h00;
    logic [7:0] divisor = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dz;

    int checks = 0;
    int errors = 0;

    div8_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    // Launch one operation and follow it to done. lat is the edge index (0 = accepting edge)
    // after which done was seen; at index inj a second start is pulsed with dd2/dv2.
    task automatic run_op(input bit now, input logic [7:0] dd, input logic [7:0] dv,
                          input int inj, input logic [7:0] dd2, input logic [7:0] dv2,
                          output int lat, output int bcnt, output bit got, output bit ovl,
                          output logic [7:0] q_mid, output logic [7:0] r_mid, output logic dz_mid);
        got = 0; ovl = 0; bcnt = 0; lat = -1;
        q_mid = 8'h00; r_mid = 8'h00; dz_mid = 1'b0;
        if (!now) @(negedge clk);
        start = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; dividend = 8'h5A; divisor = 8'h00;
        for (int k = 0; k < 20; k++) begin
            if (busy && done) ovl = 1;
            if (done) begin
                got = 1;
                lat = k;
                break;
            end
            if (busy) bcnt++;
            if (k == inj) begin
                q_mid = quotient; r_mid = remainder; dz_mid = dz;
                start = 1'b1; dividend = dd2; divisor = dv2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, dz} !== 19'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b, want all zero",
                     busy, done, quotient, remainder, dz);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [7:0] vd [6] = '{8'h16, 8'hFF, 8'h7F, 8'hFE, 8'hFF, 8'h05};
        logic [7:0] vv [6] = '{8'h12, 8'h02, 8'h7F, 8'hFF, 8'h01, 8'h00};
        logic [7:0] eq [6] = '{8'h01, 8'h7F, 8'h01, 8'h00, 8'hFF, 8'hFF};
        logic [7:0] er [6] = '{8'h04, 8'h01, 8'h00, 8'hFE, 8'h00, 8'h05};
        logic       ez [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat, bcnt, elat, ebusy;
        bit got, ovl;
        logic [7:0] qm, rm;
        logic dm;
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, vd[i], vv[i], -1, 8'h00, 8'h00, lat, bcnt, got, ovl, qm, rm, dm);
            elat  = ez[i] ? 0 : 8;
            ebusy = ez[i] ? 0 : 8;
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL vec%0d_timeout: done never seen within 20 cycles", i);
            end
            checks++;
            if (lat !== elat) begin
                errors++;
                $display("FAIL vec%0d_latency: done after edge %0d, want %0d", i, lat, elat);
            end
            checks++;
            if (bcnt !== ebusy) begin
                errors++;
                $display("FAIL vec%0d_busy_cycles: got %0d, want %0d", i, bcnt, ebusy);
            end
            checks++;
            if (ovl) begin
                errors++;
                $display("FAIL vec%0d_busy_done_overlap: got 1, want 0", i);
            end
            checks++;
            if (quotient !== eq[i] || remainder !== er[i] || dz !== ez[i]) begin
                errors++;
                $display("FAIL vec%0d_result: %h/%h got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                         i, vd[i], vv[i], quotient, remainder, dz, eq[i], er[i], ez[i]);
            end
        end
    endtask

    // Runs right after the divide-by-zero vector, so the held result is FF r 05 dz 1.
    task automatic test_midrun_start();
        int lat, bcnt;
        bit got, ovl;
        logic [7:0] qm, rm;
        logic dm;
        run_op(1'b0, 8'hC8, 8'h07, 4, 8'h10, 8'h03, lat, bcnt, got, ovl, qm, rm, dm);
        checks++;
        if (qm !== 8'hFF || rm !== 8'h05 || dm !== 1'b1) begin
            errors++;
            $display("FAIL midrun_hold: got q=%h r=%h dz=%b, want q=ff r=05 dz=1", qm, rm, dm);
        end
        checks++;
        if (!got || lat !== 8 || bcnt !== 8) begin
            errors++;
            $display("FAIL midrun_timing: got done=%0d lat=%0d busy=%0d, want 1 8 8", got, lat, bcnt);
        end
        checks++;
        if (quotient !== 8'h1C || remainder !== 8'h04 || dz !== 1'b0) begin
            errors++;
            $display("FAIL midrun_result: got q=%h r=%h dz=%b, want q=1c r=04 dz=0",
                     quotient, remainder, dz);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        bit got, ovl;
        logic [7:0] qm, rm;
        logic dm;
        run_op(1'b0, 8'h16, 8'h12, -1, 8'h00, 8'h00, lat, bcnt, got, ovl, qm, rm, dm);
        checks++;
        if (!got || quotient !== 8'h01 || remainder !== 8'h04) begin
            errors++;
            $display("FAIL b2b_first: got done=%0d q=%h r=%h, want 1 q=01 r=04", got, quotient, remainder);
        end
        run_op(1'b1, 8'h10, 8'h03, -1, 8'h00, 8'h00, lat, bcnt, got, ovl, qm, rm, dm);
        checks++;
        if (!got || lat !== 8 || bcnt !== 8 || ovl) begin
            errors++;
            $display("FAIL b2b_timing: got done=%0d lat=%0d busy=%0d ovl=%0d, want 1 8 8 0",
                     got, lat, bcnt, ovl);
        end
        checks++;
        if (quotient !== 8'h05 || remainder !== 8'h01 || dz !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got q=%h r=%h dz=%b, want q=05 r=01 dz=0", quotient, remainder, dz);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_pulse: done still %b one cycle later, want 0", done);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt;
        bit got, ovl, seen;
        logic [7:0] qm, rm;
        logic dm;
        @(negedge clk);
        start = 1'b1; dividend = 8'h64; divisor = 8'h03;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, dz} !== 19'h0) begin
            errors++;
            $display("FAIL abort_clear: got busy=%b done=%b q=%h r=%h dz=%b, want all zero",
                     busy, done, quotient, remainder, dz);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: busy/done seen after abort, want none");
        end
        run_op(1'b0, 8'h64, 8'h03, -1, 8'h00, 8'h00, lat, bcnt, got, ovl, qm, rm, dm);
        checks++;
        if (!got || lat !== 8 || quotient !== 8'h21 || remainder !== 8'h01 || dz !== 1'b0) begin
            errors++;
            $display("FAIL abort_rerun: got done=%0d lat=%0d q=%h r=%h dz=%b, want 1 8 q=21 r=01 dz=0",
                     got, lat, quotient, remainder, dz);
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        bit got, ovl;
        logic [7:0] qm, rm, dd, dv;
        logic dm;
        for (int i = 0; i < 1000; i++) begin
            dd = 8'($urandom_range(0, 255));
            dv = 8'($urandom_range(1, 255));
            run_op(1'b0, dd, dv, -1, 8'h00, 8'h00, lat, bcnt, got, ovl, qm, rm, dm);
            checks++;
            if (!got || lat !== 8) begin
                errors++;
                $display("FAIL rand%0d_timing: %h/%h got done=%0d lat=%0d, want 1 8", i, dd, dv, got, lat);
            end
            checks++;
            if (int'(quotient) * int'(dv) + int'(remainder) != int'(dd) || remainder >= dv || dz !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_result: %h/%h got q=%h r=%h dz=%b, want q*d+r=%h r<d dz=0",
                         i, dd, dv, quotient, remainder, dz, dd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_midrun_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
